// File: rtl/dmem_responder_if.sv
// Four-phase lsu2mem / mem2lsu channel pair with bundled address, write data and response.
// master = LSU side, slave = memory responder side.
interface dmem_responder_if;
  logic        lsu2mem_req_i;
  logic        lsu2mem_ack_i;
  logic        mem2lsu_ack_o;
  logic        mem2lsu_req_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic [31:0] data_err_o;

  modport master (
    output lsu2mem_req_i, lsu2mem_ack_i, data_addr_i, data_we_i, data_wdata_i,
    input  mem2lsu_ack_o, mem2lsu_req_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  lsu2mem_req_i, lsu2mem_ack_i, data_addr_i, data_we_i, data_wdata_i,
    output mem2lsu_ack_o, mem2lsu_req_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Clocked data-memory responder for the asynchronous LSU four-phase channel pair.
// Optional feature macro: DMEM_WAIT_STATE_EN stretches ACCESS to WAIT_CYCLES+1 cycles.
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dmem_responder_if.slave   bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, REQ_ACK, ACCESS, RESP, ACK_LOW} state_t;

  state_t      state;
  logic        req_m, req_s, ack_m, ack_s;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        addr_err;
  logic        access_last;
  logic        mem_we;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 1..255");
  end

`ifdef DMEM_WAIT_STATE_EN
  logic [7:0] wait_cnt;
  assign access_last = (wait_cnt == 8'd0);
`else
  assign access_last = 1'b1;
`endif

  assign idx      = addr_q[AW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign mem_we   = (state == ACCESS) && access_last && !addr_err && we_q;

  // Array has no reset; a reset during ACCESS drops state to IDLE, so mem_we never fires.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_m             <= 1'b0;
      req_s             <= 1'b0;
      ack_m             <= 1'b0;
      ack_s             <= 1'b0;
      state             <= IDLE;
      bus.mem2lsu_ack_o <= 1'b0;
      bus.mem2lsu_req_o <= 1'b0;
      bus.data_rdata_o  <= '0;
      bus.data_err_o    <= '0;
      addr_q            <= '0;
      we_q              <= 1'b0;
      wdata_q           <= '0;
`ifdef DMEM_WAIT_STATE_EN
      wait_cnt          <= '0;
`endif
    end else begin
      req_m <= bus.lsu2mem_req_i;
      req_s <= req_m;
      ack_m <= bus.lsu2mem_ack_i;
      ack_s <= ack_m;

      case (state)
        IDLE: begin
          if (req_s && !ack_s) begin
            addr_q            <= bus.data_addr_i;
            we_q              <= bus.data_we_i;
            wdata_q           <= bus.data_wdata_i;
            bus.mem2lsu_ack_o <= 1'b1;
            state             <= REQ_ACK;
          end
        end
        REQ_ACK: begin
          if (!req_s) begin
            bus.mem2lsu_ack_o <= 1'b0;
            state             <= ACCESS;
`ifdef DMEM_WAIT_STATE_EN
            wait_cnt          <= 8'(WAIT_CYCLES);
`endif
          end
        end
        ACCESS: begin
          if (access_last) begin
            if (addr_err) begin
              bus.data_rdata_o <= '0;
              bus.data_err_o   <= 32'h1;
            end else if (we_q) begin
              bus.data_rdata_o <= '0;
              bus.data_err_o   <= '0;
            end else begin
              bus.data_rdata_o <= mem[idx];
              bus.data_err_o   <= '0;
            end
            state <= RESP;
          end
`ifdef DMEM_WAIT_STATE_EN
          else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
`endif
        end
        RESP: begin
          // req rises on the first RESP edge, giving data one cycle of setup.
          bus.mem2lsu_req_o <= 1'b1;
          if (bus.mem2lsu_req_o && ack_s) begin
            bus.mem2lsu_req_o <= 1'b0;
            bus.data_rdata_o  <= '0;
            bus.data_err_o    <= '0;
            state             <= ACK_LOW;
          end
        end
        ACK_LOW: begin
          if (!ack_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: LSU-side four-phase driver with a word-array model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
`ifdef DMEM_WAIT_STATE_EN
  localparam int WAIT_EXTRA = 3;
`else
  localparam int WAIT_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;
  int   overlap = 0;
  logic [31:0] last_rdata;
  logic [31:0] ref_mem [int unsigned];

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge bus.mem2lsu_req_o) pulses++;
  always @(negedge clk) if (bus.mem2lsu_ack_o === 1'b1 && bus.mem2lsu_req_o === 1'b1) overlap++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges counted from the current point until the selected output reaches val; -1 on timeout.
  task automatic wait_sig(input int sel, input logic val, input int max, output int n);
    logic s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      s = (sel == 0) ? bus.mem2lsu_ack_o : bus.mem2lsu_req_o;
    end while (s !== val && n < max);
    if (s !== val) n = -1;
  endtask

  task automatic model(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       output logic [31:0] exp_rd, output logic [31:0] exp_err, output bit known);
    int unsigned widx;
    widx = addr >> 2;
    known = 1'b1;
    exp_rd = 32'h0;
    if (addr % 4 != 0 || widx >= DEPTH) begin
      exp_err = 32'h1;
    end else begin
      exp_err = 32'h0;
      if (we) ref_mem[widx] = wdata;
      else if (ref_mem.exists(widx)) exp_rd = ref_mem[widx];
      else known = 1'b0;
    end
  endtask

  task automatic start_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    bus.data_addr_i   = addr;
    bus.data_we_i     = we;
    bus.data_wdata_i  = wdata;
    bus.lsu2mem_req_i = 1'b1;
    wait_sig(0, 1'b1, 30, n);
    check("ack_rise_lat", 32'(n), 32'd3);
  endtask

  task automatic finish_txn(input logic [31:0] exp_rd, input logic [31:0] exp_err, input bit known);
    int n;
    logic [31:0] prev_err;
    @(negedge clk);
    bus.data_addr_i   = $urandom;
    bus.data_we_i     = 1'($urandom);
    bus.data_wdata_i  = $urandom;
    bus.lsu2mem_req_i = 1'b0;
    wait_sig(0, 1'b0, 30, n);
    check("ack_fall_lat", 32'(n), 32'd3);
    n = 0;
    prev_err = bus.data_err_o;
    do begin
      prev_err = bus.data_err_o;
      @(posedge clk); #1;
      n++;
    end while (bus.mem2lsu_req_o !== 1'b1 && n < 40);
    check("resp_req_lat", 32'(n), 32'(2 + WAIT_EXTRA));
    check("err_setup", prev_err, exp_err);
    check("err", bus.data_err_o, exp_err);
    last_rdata = bus.data_rdata_o;
    if (known) check("rdata", bus.data_rdata_o, exp_rd);
    @(negedge clk);
    bus.lsu2mem_ack_i = 1'b1;
    wait_sig(1, 1'b0, 30, n);
    check("resp_req_fall_lat", 32'(n), 32'd3);
    check("rdata_clr", bus.data_rdata_o, 32'h0);
    check("err_clr", bus.data_err_o, 32'h0);
    @(negedge clk);
    bus.lsu2mem_ack_i = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    logic [31:0] er, ee;
    bit k;
    model(addr, we, wdata, er, ee, k);
    start_txn(addr, we, wdata);
    finish_txn(er, ee, k);
  endtask

  initial begin
    int p0, n, seen;
    logic [31:0] d, a, er, ee;
    bit k;

    bus.lsu2mem_req_i = 1'b0;
    bus.lsu2mem_ack_i = 1'b0;
    bus.data_addr_i   = '0;
    bus.data_we_i     = 1'b0;
    bus.data_wdata_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, bus.mem2lsu_ack_o}, 32'h0);
    check("rst_req", {31'b0, bus.mem2lsu_req_o}, 32'h0);
    check("rst_rdata", bus.data_rdata_o, 32'h0);
    check("rst_err", bus.data_err_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed write/read, misaligned write, out-of-range and last-word reads
    do_txn(32'h10, 1'b1, 32'hDEADBEEF);
    do_txn(32'h10, 1'b0, 32'h0);
    check("tp_read_10", last_rdata, 32'hDEADBEEF);
    do_txn(32'h13, 1'b1, 32'h1234);
    do_txn(32'h10, 1'b0, 32'h0);
    check("tp_read_10_after_misaligned", last_rdata, 32'hDEADBEEF);
    do_txn(32'h1000, 1'b0, 32'h0);
    do_txn(32'hFFC, 1'b0, 32'h0);

    // Back-to-back write/read pairs
    p0 = pulses;
    for (int unsigned i = 0; i < 8; i++) begin
      d = $urandom;
      do_txn(32'(i * 4), 1'b1, d);
      do_txn(32'(i * 4), 1'b0, 32'h0);
    end
    check("b2b_pulses", 32'(pulses - p0), 32'd16);

    // Randomized mix across regions
    for (int unsigned i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0: do_txn({20'h0, 4'($urandom_range(8, 15)), 8'h0} | 32'($urandom_range(0, 15) * 4), 1'b1, $urandom);
        1: do_txn({20'h0, 4'($urandom_range(8, 15)), 8'h0} | 32'($urandom_range(0, 15) * 4), 1'b0, 32'h0);
        2: do_txn(($urandom & 32'hFFC) | 32'($urandom_range(1, 3)), 1'($urandom), $urandom);
        3: do_txn(32'(DEPTH * 4) + ($urandom & 32'h7FFF_FFFC), 1'($urandom), $urandom);
        default: do_txn(32'hFFC, 1'($urandom), $urandom);
      endcase
    end

    // Reset while in ACCESS: the write must not land
    start_txn(32'h1C, 1'b1, ~ref_mem[7]);
    @(negedge clk);
    bus.lsu2mem_req_i = 1'b0;
    wait_sig(0, 1'b0, 30, n);
    check("access_entry_lat", 32'(n), 32'd3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    do_txn(32'h1C, 1'b0, 32'h0);

    // Reset while in RESP, then LSU ack held high across release
    start_txn(32'h1C, 1'b0, 32'h0);
    @(negedge clk);
    bus.lsu2mem_req_i = 1'b0;
    wait_sig(0, 1'b0, 30, n);
    wait_sig(1, 1'b1, 40, n);
    check("resp_reached", {31'b0, bus.mem2lsu_req_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_resp_req", {31'b0, bus.mem2lsu_req_o}, 32'h0);
    check("rst_resp_rdata", bus.data_rdata_o, 32'h0);
    check("rst_resp_err", bus.data_err_o, 32'h0);
    @(negedge clk);
    bus.lsu2mem_ack_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.data_addr_i   = 32'h1C;
    bus.data_we_i     = 1'b0;
    bus.lsu2mem_req_i = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.mem2lsu_ack_o !== 1'b0) seen++;
    end
    check("no_accept_while_ack", 32'(seen), 32'h0);
    @(negedge clk);
    bus.lsu2mem_ack_i = 1'b0;
    wait_sig(0, 1'b1, 30, n);
    check("accept_after_ack_drop", 32'(n), 32'd3);
    model(32'h1C, 1'b0, 32'h0, er, ee, k);
    finish_txn(er, ee, k);

    a = 32'h4;
    do_txn(a, 1'b0, 32'h0);
    check("ack_req_overlap", 32'(overlap), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
